// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding one UART transmitter
// Grants one requester per frame; watchdog aborts if the transmitter never goes busy.
module uart_tx_arbiter #(
   parameter  int DATA = 8,
   parameter  int NREQ = 4,
   parameter  int TMO  = 16,
   localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW   = $clog2(TMO + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DATA-1:0] req_data,
   output logic [NREQ-1:0]      ack,
   output logic                 tx_start,
   output logic [DATA-1:0]      tx_data,
   input  logic                 tx_busy,
   output logic [GW-1:0]        grant_id,
   output logic                 active,
   output logic                 timeout,
   output logic [15:0]          frame_cnt
);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t          state, state_nxt;
   logic [GW-1:0]   last;
   logic [GW-1:0]   win;
   logic [DATA-1:0] win_data;
   logic [CW-1:0]   cnt;
   logic            do_grant, do_tmo, do_done;

   // Search begins one past the previous winner so every requester gets a turn.
   always_comb begin
      logic          found;
      logic [GW-1:0] cand;
      int            idx;
      found = 1'b0;
      win   = last;
      cand  = '0;
      for (int off = 1; off <= NREQ; off++) begin
         idx  = (int'(last) + off) % NREQ;
         cand = GW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == GW'(i)) win_data = req_data[i*DATA +: DATA];
      end
   end

   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_tmo    = 1'b0;
      do_done   = 1'b0;
      case (state)
         IDLE: begin
            if ((|req) && !tx_busy) begin
               state_nxt = START;
               do_grant  = 1'b1;
            end
         end
         START: state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (cnt == CW'(TMO - 1)) begin
               state_nxt = IDLE;
               do_tmo    = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_nxt = IDLE;
               do_done   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tx_data   <= '0;
         grant_id  <= '0;
         last      <= GW'(NREQ - 1);
         cnt       <= '0;
         timeout   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state   <= state_nxt;
         timeout <= do_tmo;
         if (do_grant) begin
            tx_data  <= win_data;
            grant_id <= win;
            last     <= win;
         end
         if (state == WAIT_BUSY && !tx_busy && !do_tmo) cnt <= cnt + 1'b1;
         else                                          cnt <= '0;
         if (do_done) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Strobes decode straight from state so an async reset clears them in the same cycle.
   always_comb begin
      ack = '0;
      if (state == START) ack[grant_id] = 1'b1;
   end

   assign tx_start = (state == START);
   assign active   = (state != IDLE);

endmodule
